// File: rtl/instr_rom_loader.sv
// Instruction ROM: byte-serial big-endian loader, combinational fetch port, fetch monitor.
// Optional running XOR of committed words when INSTR_ROM_CHECKSUM_EN is defined.
module instr_rom_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_done,
  output logic        load_overflow,
  output logic [31:0] fetch_count,
  output logic        halted,
  output logic        oob,
  output logic [31:0] checksum
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN = 32'(4 * DEPTH_WORDS);

  typedef enum logic {
    LOAD,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   asm_q, asm_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          hlt_q, hlt_d;
  logic          oob_q, oob_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          full;
  logic          accept;
  logic          we;
  logic [31:0]   wword;
  logic [31:0]   offset;
  logic          in_win;

  assign full      = (ptr_q == (AW+1)'(DEPTH_WORDS));
  assign load_ready = (state_q == LOAD) && !full;
  assign load_done = (state_q == DONE);
  assign accept    = load_valid && load_ready;

  // New byte lands in the lane selected by the byte counter, MSB first
  assign wword = asm_q | ({load_byte, 24'b0} >> {bcnt_q, 3'b0});

  assign offset = instr_address - BASE_ADDR;
  assign in_win = (offset < WIN) && (offset[1:0] == 2'b00);

  assign instr_readdata = (load_done && in_win) ? mem[offset[AW+1:2]] : 32'h0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (bcnt_q == 2'd3 || load_last) begin
            we     = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            bcnt_d = 2'd0;
            asm_d  = 32'h0;
            if (load_last) state_d = DONE;
          end else begin
            asm_d  = wword;
            bcnt_d = bcnt_q + 2'd1;
          end
        end else if (full && load_valid) begin
          ovf_d = 1'b1;
          if (load_last) state_d = DONE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // Monitor sees the registered load_done, so it lags the commit edge by one
  always_comb begin
    cnt_d = cnt_q;
    hlt_d = hlt_q;
    oob_d = oob_q;
    if (clk_enable && load_done && !hlt_q) begin
      unique case (1'b1)
        (instr_address == 32'h0): hlt_d = 1'b1;
        in_win:                   cnt_d = cnt_q + 32'd1;
        default:                  oob_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      bcnt_q  <= 2'd0;
      asm_q   <= 32'h0;
      ovf_q   <= 1'b0;
      cnt_q   <= 32'h0;
      hlt_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      hlt_q   <= hlt_d;
      oob_q   <= oob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr_q[AW-1:0]] <= wword;
  end

  assign load_overflow = ovf_q;
  assign fetch_count   = cnt_q;
  assign halted        = hlt_q;
  assign oob           = oob_q;

`ifdef INSTR_ROM_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (!reset)  csum_q <= 32'h0;
    else if (we) csum_q <= csum_q ^ wword;
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Instruction-side memory responder for mips_cpu_harvard. It answers the CPU's instr_address fetches with instr_readdata from a word array.
- The array is filled beforehand through a byte-serial valid/ready load port, replacing hard-coded instruction decode in benches.
- It also monitors the fetch stream. It counts fetches and flags halt (fetch of address 0) and out-of-window fetches.
- Sits beside data_memory in every CPU test harness.

Parameters:
- BASE_ADDR, 32'hBFC00000: byte address of word 0 (reset vector).
- DEPTH_WORDS, 256: array depth in 32-bit words; must be a power of two, ≥4.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- clk_enable  in  1  gates fetch-monitor updates only; loader and reads are unaffected.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched word, combinational.
- load_valid  in  1  load byte offered.
- load_ready  out  1  loader accepts byte this cycle.
- load_byte  in  8  load data.
- load_last  in  1  final byte of image, qualified by load_valid&&load_ready.
- load_done  out  1  image committed, array readable.
- load_overflow  out  1  sticky: byte offered while array full.
- fetch_count  out  32  enabled cycles with a valid fetch since load_done.
- halted  out  1  sticky: fetch of address 0 seen.
- oob  out  1  sticky: fetch outside window or misaligned.
- checksum  out  32  running XOR of committed words (optional feature).

Behaviour:
- Reset (reset==0 at posedge) values:
  - load_done=0, load_overflow=0, halted=0, oob=0, fetch_count=0, checksum=0.
  - Write pointer=0, byte counter=0, FSM=LOAD.
  - Array contents are NOT cleared.
  - Reset mid-load abandons the partial word and restarts at word 0.
- Loader FSM states:
  - LOAD: load_ready=1 while the write pointer is below DEPTH_WORDS.
  - DONE: load_ready=0.
- Byte assembly in LOAD:
  - Big-endian: the 1st accepted byte goes to bits[31:24], the 2nd to [23:16], the 3rd to [15:8], the 4th to [7:0].
  - On the 4th accepted byte the word is written to array[ptr] at that edge, then ptr+1 and byte counter=0.
- load_last:
  - Accepted with a partial word: unfilled low bytes are zero-padded and the word is committed in the same edge.
  - Accepted on a 4th byte: normal commit.
  - Either way, FSM→DONE and load_done=1 on that edge.
- Full array:
  - When ptr==DEPTH_WORDS, load_ready=0 and the FSM stays in LOAD.
  - Any load_valid=1 then sets load_overflow. Bytes are dropped.
  - load_last on a full array with load_valid=1 still moves the FSM→DONE.
- In DONE, load_valid is ignored. Only reset returns the FSM to LOAD.
- Read path:
  - Combinational: instr_readdata=array[(instr_address-BASE_ADDR)>>2] when all of the following hold:
    - load_done=1;
    - instr_address[1:0]==0;
    - BASE_ADDR ≤ instr_address < BASE_ADDR+4*DEPTH_WORDS.
  - Otherwise instr_readdata=0 (NOP).
  - Words past the committed pointer return whatever is stored; unwritten words are not defined by this spec.
- Fetch monitor (posedge, clk_enable=1, load_done=1, halted=0):
  - instr_address==0: halted←1; fetch_count does not increment.
  - Address in window and aligned: fetch_count+1 (wraps at 2^32).
  - Any other address (nonzero): oob←1, no count.
- After halted=1, fetch_count freezes.
- Flags are sticky until reset.
- Same-edge load_done and fetch: the monitor uses the registered load_done. The first count can therefore occur no earlier than one edge after load_done rises.

Optional Feature:
- INSTR_ROM_CHECKSUM_EN defined:
  - checksum←checksum^word on every commit, including zero-padded words.
  - Reset clears it.
- Undefined:
  - checksum tied to 0, no XOR logic generated.
  - The port still exists.

Test Plan:
- Load 8 bytes 24 84 FF FF 00 04 24 00 (last on 8th) → array[0]=32'h2484FFFF, array[1]=32'h00042400; load_done=1 after 8th byte; fetch BFC00004 returns 32'h00042400.
- Load 5 bytes 01 02 03 04 AA (last on 5th) → array[1]=32'hAA000000, load_done=1; with INSTR_ROM_CHECKSUM_EN checksum=32'hAB020304, without it 0.
- DEPTH_WORDS=4, offer 17 bytes → load_ready=0 after 16th; load_overflow=1 on 17th; array[3] holds bytes 13–16; load_last on a later offered byte → load_done=1.
- After load, run 3 enabled fetches BFC00000/04/08, then address 0 → fetch_count=3, halted=1; further fetches leave count at 3. With clk_enable=0 → no change.
- Fetch BFC00002 and 00001000 → instr_readdata=0, oob=1, fetch_count unchanged.
- Drive reset=0 for one edge after 2 bytes of a word → load_ready=1, load_done=0; next 4 bytes 11 22 33 44 with last → array[0]=32'h11223344.
